// File: rtl/vga_pixel_writer_if.sv
// Pixel stream from the object generator plus the plot port toward the VGA adapter.
// The writer takes the slave side; the generator/adapter environment takes the master side.
interface vga_pixel_writer_if;
    logic       pix_valid;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_colour;
    logic       pix_last;
    logic       pix_ready;
    logic       vga_hold;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_colour, pix_last, vga_hold,
        output pix_ready, vga_x, vga_y, vga_colour, vga_plot
    );

    modport master (
        output pix_valid, pix_x, pix_y, pix_colour, pix_last, vga_hold,
        input  pix_ready, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/vga_pixel_writer.sv
// Clears the screen to a background colour, then streams clipped object pixels
// through a small FIFO to the VGA adapter, one plot per un-held cycle.
module vga_pixel_writer #(
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned SCREEN_H   = 120,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    vga_pixel_writer_if.slave bus,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned      PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [7:0]       X_LAST   = 8'(SCREEN_W - 1);
    localparam logic [6:0]       Y_LAST   = 7'(SCREEN_H - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       cx;
    logic [6:0]       cy;
    pixel_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic fifo_empty;
    logic fifo_full;
    logic in_range;
    logic clear_end;
    logic clear_emit;
    logic accept;
    logic push;
    logic pop;
    logic done_set;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign in_range   = (32'(bus.pix_x) < SCREEN_W) && (32'(bus.pix_y) < SCREEN_H);
    assign clear_end  = (cx == X_LAST) && (cy == Y_LAST);

    // Pure state/count decodes: independent of vga_hold and pix_valid.
    assign bus.pix_ready = (state == STREAM) && !fifo_full;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clear_emit = 1'b0;
        accept     = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        done_set   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (!bus.vga_hold) begin
                    clear_emit = 1'b1;
                    if (clear_end) begin
                        state_next = STREAM;
                    end
                end
            end
            STREAM: begin
                // Off-screen pixels are consumed (accepted) but never pushed.
                accept = bus.pix_valid && !fifo_full;
                push   = accept && in_range;
                pop    = !fifo_empty && !bus.vga_hold;
                if (accept && bus.pix_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                pop = !fifo_empty && !bus.vga_hold;
                if (fifo_empty) begin
                    done_set   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Clear scan, FIFO bookkeeping and registered plot outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx             <= '0;
            cy             <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.vga_plot   <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            bus.vga_plot <= 1'b0;
            frame_done   <= done_set;

            if (state == IDLE) begin
                cx     <= '0;
                cy     <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end

            if (clear_emit) begin
                bus.vga_x      <= cx;
                bus.vga_y      <= cy;
                bus.vga_colour <= BG_COLOUR;
                bus.vga_plot   <= 1'b1;
                if (cx == X_LAST) begin
                    cx <= '0;
                    cy <= cy + 7'd1;
                end else begin
                    cx <= cx + 8'd1;
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (pop) begin
                rd_ptr         <= rd_ptr + PTR_W'(1);
                bus.vga_x      <= mem[rd_ptr].x;
                bus.vga_y      <= mem[rd_ptr].y;
                bus.vga_colour <= mem[rd_ptr].colour;
                bus.vga_plot   <= 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Pixel storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{x: bus.pix_x, y: bus.pix_y, colour: bus.pix_colour};
        end
    end

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Scoreboard bench for vga_pixel_writer: expected plots are queued as stimulus is
// driven and a monitor pops/compares them whenever the DUT strobes vga_plot.
module tb_vga_pixel_writer;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         t;
    } exp_t;

    logic clk;
    logic reset;
    logic frame_start;
    logic busy;
    logic frame_done;

    vga_pixel_writer_if vif ();

    vga_pixel_writer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .bus         (vif),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int   errors        = 0;
    int   checks        = 0;
    int   cyc           = 0;
    int   plots         = 0;
    int   last_plot_cyc = 0;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Plot monitor: every strobe must match the scoreboard head and not follow a held edge.
    always @(posedge clk) begin : monitor
        logic h;
        exp_t e;
        h = vif.vga_hold;
        #1;
        if (vif.vga_plot === 1'b1) begin
            plots++;
            last_plot_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL plot_unexpected: got (%0d,%0d) colour %0d at cycle %0d, required no plot",
                         vif.vga_x, vif.vga_y, vif.vga_colour, cyc);
            end else begin
                e = sb.pop_front();
                if (h || vif.vga_x !== e.x || vif.vga_y !== e.y || vif.vga_colour !== e.c ||
                    (e.t >= 0 && cyc != e.t)) begin
                    errors++;
                    $display("FAIL plot_check: got (%0d,%0d) colour %0d cycle %0d hold %0b, required (%0d,%0d) colour %0d cycle %0d hold 0",
                             vif.vga_x, vif.vga_y, vif.vga_colour, cyc, h, e.x, e.y, e.c, e.t);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required bench completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_clear(input int t0);
        exp_t e;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                e.x = 8'(x);
                e.y = 7'(y);
                e.c = 3'd0;
                e.t = (t0 < 0) ? -1 : t0 + y * 160 + x;
                sb.push_back(e);
            end
        end
    endtask

    task automatic send_pix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                            input logic last, input bit exp_plot, input bit timed);
        int   n;
        exp_t e;
        n              = 0;
        vif.pix_valid  = 1'b1;
        vif.pix_x      = x;
        vif.pix_y      = y;
        vif.pix_colour = c;
        vif.pix_last   = last;
        while (vif.pix_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL send_timeout: pix_ready %b after %0d cycles, required 1", vif.pix_ready, n);
        end else if (exp_plot) begin
            e.x = x;
            e.y = y;
            e.c = c;
            e.t = timed ? cyc + 2 : -1;
            sb.push_back(e);
        end
        step();
        vif.pix_valid = 1'b0;
        vif.pix_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        frame_start    = 1'b0;
        vif.pix_valid  = 1'b0;
        vif.pix_x      = '0;
        vif.pix_y      = '0;
        vif.pix_colour = '0;
        vif.pix_last   = 1'b0;
        vif.vga_hold   = 1'b0;
        repeat (3) step();
        checks++; if (vif.vga_x !== 8'd0) begin errors++; $display("FAIL reset_vga_x: got %0d, required 0", vif.vga_x); end
        checks++; if (vif.vga_y !== 7'd0) begin errors++; $display("FAIL reset_vga_y: got %0d, required 0", vif.vga_y); end
        checks++; if (vif.vga_colour !== 3'd0) begin errors++; $display("FAIL reset_vga_colour: got %0d, required 0", vif.vga_colour); end
        checks++; if (vif.vga_plot !== 1'b0) begin errors++; $display("FAIL reset_vga_plot: got %b, required 0", vif.vga_plot); end
        checks++; if (vif.pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready: got %b, required 0", vif.pix_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
        reset = 1'b0;
        repeat (2) step();
        checks++;
        if (busy !== 1'b0 || vif.vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: got busy %b plot %b, required 0 0", busy, vif.vga_plot);
        end
    endtask

    task automatic test_clear(input int toggle_cycles);
        int n;
        int p0;
        int rdy_bad;
        vif.vga_hold = 1'b0;
        frame_start  = 1'b1;
        push_clear((toggle_cycles == 0) ? cyc + 2 : -1);
        p0 = plots;
        step();
        frame_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || vif.vga_plot !== 1'b0 || vif.pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_entry: got busy %b plot %b ready %b, required 1 0 0", busy, vif.vga_plot, vif.pix_ready);
        end
        n       = 0;
        rdy_bad = 0;
        while (plots - p0 < 19200 && n < 45000) begin
            if (vif.pix_ready !== 1'b0) rdy_bad++;
            vif.vga_hold = (n < toggle_cycles) ? ((n % 2) == 1) : 1'b0;
            step();
            n++;
        end
        vif.vga_hold = 1'b0;
        checks++;
        if (plots - p0 != 19200) begin
            errors++;
            $display("FAIL clear_count: got %0d plots, required 19200", plots - p0);
        end
        checks++;
        if (rdy_bad != 0) begin
            errors++;
            $display("FAIL clear_ready: got pix_ready high on %0d cycles, required 0", rdy_bad);
        end
        if (toggle_cycles == 0) begin
            checks++;
            if (n != 19200) begin
                errors++;
                $display("FAIL clear_cycles: got %0d cycles, required 19200", n);
            end
        end
        checks++;
        if (busy !== 1'b1 || vif.pix_ready !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL clear_to_stream: got busy %b ready %b pending %0d, required 1 1 0", busy, vif.pix_ready, sb.size());
        end
    endtask

    task automatic wait_done(input string name, input int want_cyc, input int want_plot_cyc, input bit plot_expected);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (frame_done !== 1'b1 || cyc != want_cyc || busy !== 1'b0 ||
            (plot_expected && last_plot_cyc != want_plot_cyc)) begin
            errors++;
            $display("FAIL %s_done: got done %b cycle %0d busy %b last plot %0d, required 1 %0d 0 %0d",
                     name, frame_done, cyc, busy, last_plot_cyc, want_cyc, want_plot_cyc);
        end
        step();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: got frame_done %b one cycle later, required 0", name, frame_done);
        end
    endtask

    task automatic test_box();
        int c0;
        int ce;
        c0 = cyc;
        for (int i = 0; i < 6; i++) begin
            send_pix(8'(10 + i % 3), 7'(20 + i / 3), 3'd5, (i == 5), 1'b1, 1'b1);
        end
        ce = cyc;
        checks++;
        if (ce - c0 != 6) begin
            errors++;
            $display("FAIL box_throughput: got %0d cycles for 6 pixels, required 6", ce - c0);
        end
        checks++;
        if (vif.pix_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL box_drain_ready: got ready %b busy %b, required 0 1", vif.pix_ready, busy);
        end
        wait_done("box", ce + 2, ce + 1, 1'b1);
    endtask

    task automatic test_hold_fifo();
        int p;
        int rdy_bad;
        int n;
        p            = plots;
        vif.vga_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_pix(8'(30 + i), 7'd40, 3'(i + 1), 1'b0, 1'b1, 1'b0);
        end
        rdy_bad        = 0;
        vif.pix_valid  = 1'b1;
        vif.pix_x      = 8'd50;
        vif.pix_y      = 7'd50;
        vif.pix_colour = 3'd7;
        for (int i = 0; i < 6; i++) begin
            if (vif.pix_ready !== 1'b0) rdy_bad++;
            step();
        end
        checks++;
        if (rdy_bad != 0 || plots != p) begin
            errors++;
            $display("FAIL hold_full: got ready-high cycles %0d plots %0d, required 0 0", rdy_bad, plots - p);
        end
        vif.pix_valid = 1'b0;
        vif.vga_hold  = 1'b0;
        step();
        checks++;
        if (plots != p + 1 || vif.pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got plots %0d ready %b, required 1 1", plots - p, vif.pix_ready);
        end
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (plots != p + 4) begin
            errors++;
            $display("FAIL hold_drain: got %0d plots, required 4", plots - p);
        end
    endtask

    task automatic test_clip();
        int p;
        p = plots;
        send_pix(8'd170, 7'd5, 3'd2, 1'b0, 1'b0, 1'b0);
        send_pix(8'd5, 7'd125, 3'd3, 1'b0, 1'b0, 1'b0);
        send_pix(8'd159, 7'd119, 3'd6, 1'b1, 1'b1, 1'b1);
        wait_done("clip", cyc + 2, cyc + 1, 1'b1);
        checks++;
        if (plots != p + 1) begin
            errors++;
            $display("FAIL clip_count: got %0d plots, required 1", plots - p);
        end
    endtask

    task automatic test_clip_last();
        int p;
        p = plots;
        send_pix(8'd200, 7'd0, 3'd4, 1'b1, 1'b0, 1'b0);
        wait_done("clip_last", cyc + 1, 0, 1'b0);
        checks++;
        if (plots != p) begin
            errors++;
            $display("FAIL clip_last_count: got %0d plots, required 0", plots - p);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        int p0;
        vif.vga_hold = 1'b0;
        frame_start  = 1'b1;
        push_clear(-1);
        p0 = plots;
        step();
        frame_start = 1'b0;
        n = 0;
        while (plots - p0 < 9600 && n < 20000) begin
            step();
            n++;
        end
        checks++;
        if (plots - p0 != 9600) begin
            errors++;
            $display("FAIL mid_clear_reach: got %0d plots, required 9600", plots - p0);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({vif.vga_x, vif.vga_y, vif.vga_colour, vif.vga_plot, vif.pix_ready, busy, frame_done} !== 22'd0) begin
            errors++;
            $display("FAIL mid_clear_reset: got x %0d y %0d c %0d plot %b ready %b busy %b done %b, required all 0",
                     vif.vga_x, vif.vga_y, vif.vga_colour, vif.vga_plot, vif.pix_ready, busy, frame_done);
        end
        sb.delete();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_stream();
        vif.vga_hold = 1'b1;
        send_pix(8'd70, 7'd70, 3'd1, 1'b0, 1'b1, 1'b0);
        send_pix(8'd71, 7'd71, 3'd2, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if ({vif.vga_x, vif.vga_y, vif.vga_colour, vif.vga_plot, vif.pix_ready, busy, frame_done} !== 22'd0) begin
            errors++;
            $display("FAIL mid_stream_reset: got x %0d y %0d c %0d plot %b ready %b busy %b done %b, required all 0",
                     vif.vga_x, vif.vga_y, vif.vga_colour, vif.vga_plot, vif.pix_ready, busy, frame_done);
        end
        sb.delete();
        step();
        reset        = 1'b0;
        vif.vga_hold = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_clear(0);
        test_box();
        test_clear(2000);
        test_hold_fifo();
        test_clip();
        test_reset_mid_clear();
        test_clear(0);
        test_reset_mid_stream();
        test_clear(0);
        test_clip_last();
        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
